// File: rtl/seg7_scan_reader.sv
// Receive side of a scanned active-low 7-segment bus: decodes stable digits and assembles
// frames aligned to digit 0. Define SEG7_HEX_EN to also decode the hex letters A..F.
module seg7_scan_reader #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en_in,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] StableMax = 4'(STABLE_CNT);

  typedef enum logic [0:0] {StSync, StCollect} state_e;

  // Returns {err, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
`ifdef SEG7_HEX_EN
      7'b0001000: r = 5'h0a;
      7'b0000011: r = 5'h0b;
      7'b1000110: r = 5'h0c;
      7'b0100001: r = 5'h0d;
      7'b0000110: r = 5'h0e;
      7'b0001110: r = 5'h0f;
`endif
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [6:0]            seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] den_q;
  logic [KW-1:0]         prev_k_q;
  logic                  prev_slot_q;
  logic [3:0]            cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]      shadow_err_q, shadow_err_d;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [3:0]    nlow;
  logic [KW-1:0] k;
  logic          slot, same, capture, xfer;
  logic [4:0]    dec;

  always_comb begin
    nlow = '0;
    k    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!den_q[i]) begin
        nlow = nlow + 4'd1;
        k    = KW'(i);
      end
    end
  end

  assign slot = (nlow == 4'd1);
  assign same = slot && prev_slot_q && (k == prev_k_q) && (seg_q == prev_seg_q);
  assign dec  = decode(seg_q);

  always_comb begin
    if (!slot) begin
      cnt_d = '0;
    end else if (same) begin
      cnt_d = (cnt_q == StableMax) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd1;
    end
  end

  // A saturated counter holding its value is the same dwell, not a new capture
  assign capture = slot && (cnt_d == StableMax) && !(same && (cnt_q == StableMax));

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    xfer         = 1'b0;
    case (state_q)
      StSync: begin
        if (capture && (k == '0)) begin
          shadow_d[0]     = dec[3:0];
          shadow_err_d[0] = dec[4];
          mask_d          = '0;
          mask_d[0]       = 1'b1;
          state_d         = StCollect;
        end
      end
      StCollect: begin
        if (mask_q == '1) begin
          xfer    = 1'b1;
          mask_d  = '0;
          state_d = StSync;
        end else if (capture) begin
          shadow_d[k]     = dec[3:0];
          shadow_err_d[k] = dec[4];
          if (k == '0) begin
            mask_d    = '0;
            mask_d[0] = 1'b1;
          end else begin
            mask_d[k] = 1'b1;
          end
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_comb begin
    digits_d  = digits_q;
    err_d     = err_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (xfer) begin
      digits_d  = shadow_q;
      err_d     = shadow_err_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !out_ready;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= '1;
      den_q        <= '1;
      prev_seg_q   <= '1;
      prev_k_q     <= '0;
      prev_slot_q  <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StSync;
      mask_q       <= '0;
      shadow_q     <= '0;
      shadow_err_q <= '0;
      digits_q     <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      seg_q        <= seg_in;
      den_q        <= dig_en_in;
      prev_seg_q   <= seg_q;
      prev_k_q     <= k;
      prev_slot_q  <= slot;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      shadow_err_q <= shadow_err_d;
      digits_q     <= digits_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_digits = digits_q;
  assign out_err    = err_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: a run-length/frame model compared every cycle,
// plus directed scans with hand-computed frames.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 3;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
    7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
    7'b0000110, 7'b0001110};
`ifdef SEG7_HEX_EN
  localparam int NLEGAL = 16;
`else
  localparam int NLEGAL = 10;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_in = 7'h7f;
  logic [ND-1:0]   dig_en_in = '1;
  logic [4*ND-1:0] out_digits;
  logic [ND-1:0]   out_err;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            overrun;

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en_in  (dig_en_in),
    .out_digits (out_digits),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]      m_seg = 7'h7f, m_prev_seg = 7'h7f;
  logic [ND-1:0]   m_den = '1;
  int              m_run = 0, m_prev_k = 0, m_lows, m_k;
  bit              m_prev_ok = 0, m_cap, m_pending = 0;
  logic [ND-1:0]   m_have = '0;
  logic [3:0]      m_nib [ND];
  logic            m_errv [ND];
  logic [3:0]      d_nib;
  logic            d_err;
  logic [4*ND-1:0] exp_digits = '0;
  logic [ND-1:0]   exp_err = '0;
  logic            exp_valid = 1'b0, exp_over = 1'b0;
  int              m_frames = 0;

  function automatic void mdec(input logic [6:0] p, output logic [3:0] n, output logic e);
    n = 4'h0;
    e = 1'b1;
    for (int i = 0; i < NLEGAL; i++) begin
      if (p == PAT[i]) begin
        n = 4'(i);
        e = 1'b0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seg = 7'h7f; m_den = '1; m_prev_seg = 7'h7f; m_prev_k = 0; m_prev_ok = 0;
      m_run = 0; m_have = '0; m_pending = 0;
      exp_digits = '0; exp_err = '0; exp_valid = 1'b0; exp_over = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_nib[i] = 4'h0;
        m_errv[i] = 1'b0;
      end
    end else begin
      m_lows = 0;
      m_k = 0;
      for (int i = 0; i < ND; i++) begin
        if (!m_den[i]) begin
          m_lows++;
          m_k = i;
        end
      end
      m_cap = 0;
      if (m_lows == 1) begin
        if (m_prev_ok && m_k == m_prev_k && m_seg == m_prev_seg) m_run++;
        else m_run = 1;
        m_cap = (m_run == SC);
      end else begin
        m_run = 0;
      end
      m_prev_ok = (m_lows == 1);
      m_prev_k = m_k;
      m_prev_seg = m_seg;
      exp_over = 1'b0;
      if (m_pending) begin
        exp_over = exp_valid && !out_ready;
        for (int i = 0; i < ND; i++) begin
          exp_digits[4*i +: 4] = m_nib[i];
          exp_err[i] = m_errv[i];
        end
        exp_valid = 1'b1;
        m_pending = 0;
        m_have = '0;
        m_frames++;
      end else begin
        if (exp_valid && out_ready) exp_valid = 1'b0;
        if (m_cap && (m_k == 0 || m_have != '0)) begin
          mdec(m_seg, d_nib, d_err);
          m_nib[m_k] = d_nib;
          m_errv[m_k] = d_err;
          if (m_k == 0) m_have = '0;
          m_have[m_k] = 1'b1;
          if (m_have == '1) m_pending = 1;
        end
      end
      m_seg = seg_in;
      m_den = dig_en_in;
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int              cyc = 0;
  int              first_valid_cyc = -1;
  int              n_over = 0;
  logic [4*ND-1:0] last_frame = '0;
  logic [ND-1:0]   last_err = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("cyc_digits", 32'(out_digits), 32'(exp_digits));
    check("cyc_err", 32'(out_err), 32'(exp_err));
    check("cyc_valid", 32'(out_valid), 32'(exp_valid));
    check("cyc_overrun", 32'(overrun), 32'(exp_over));
    if (out_valid) begin
      last_frame = out_digits;
      last_err = out_err;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (overrun) n_over++;
  end

  // ---------------- stimulus ----------------
  task automatic show(input int k, input logic [6:0] p, input int n);
    dig_en_in = '1;
    dig_en_in[k] = 1'b0;
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    dig_en_in = '1;
    seg_in = 7'h7f;
    repeat (n) @(negedge clk);
  endtask

  int t3, f0, o0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_digits", 32'(out_digits), 32'h0);
    check("rst_err", 32'(out_err), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame and latency
    f0 = m_frames;
    show(0, PAT[1], 5);
    show(1, PAT[2], 5);
    show(2, PAT[3], 5);
    t3 = cyc;
    show(3, PAT[4], 5);
    blank(4);
    #1;
    check("t1_frame", 32'(last_frame), 32'h4321);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_latency", 32'(first_valid_cyc - t3), 32'd5);
    check("t1_model", 32'(exp_digits), 32'h4321);
    check("t1_count", 32'(m_frames - f0), 32'd1);

    // Scan starting mid-frame
    f0 = m_frames;
    show(2, PAT[7], 5);
    show(3, PAT[6], 5);
    show(0, PAT[9], 5);
    show(1, PAT[8], 5);
    show(2, PAT[7], 5);
    show(3, PAT[6], 5);
    blank(4);
    #1;
    check("t2_frame", 32'(last_frame), 32'h6789);
    check("t2_count", 32'(m_frames - f0), 32'd1);

    // Hex letter on digit 1
    show(0, PAT[0], 4);
    show(1, 7'b0001000, 4);
    show(2, PAT[0], 4);
    show(3, PAT[0], 4);
    blank(4);
    #1;
`ifdef SEG7_HEX_EN
    check("t3_frame", 32'(last_frame), 32'h00a0);
    check("t3_err", 32'(last_err), 32'h0);
`else
    check("t3_frame", 32'(last_frame), 32'h0000);
    check("t3_err", 32'(last_err), 32'h2);
`endif

    // Glitch and double-enable
    f0 = m_frames;
    show(0, PAT[5], 2);
    show(0, PAT[6], 3);
    dig_en_in = 4'b1100;
    seg_in = PAT[1];
    repeat (10) @(negedge clk);
    #1;
    check("t4_nocap_count", 32'(m_frames - f0), 32'd0);
    check("t4_nocap_valid", 32'(out_valid), 32'h0);
    show(1, PAT[1], 4);
    show(2, PAT[2], 4);
    show(3, PAT[3], 4);
    blank(4);
    #1;
    check("t4_frame", 32'(last_frame), 32'h3216);

    // Overrun with consumer stalled
    out_ready = 1'b0;
    o0 = n_over;
    for (int i = 0; i < ND; i++) show(i, PAT[1], 4);
    blank(4);
    #1;
    check("t5_first_valid", 32'(out_valid), 32'h1);
    check("t5_first_frame", 32'(out_digits), 32'h1111);
    for (int i = 0; i < ND; i++) show(i, PAT[2], 4);
    blank(4);
    #1;
    check("t5_overruns", 32'(n_over - o0), 32'd1);
    check("t5_frame", 32'(out_digits), 32'h2222);
    blank(3);
    #1;
    check("t5_held", 32'(out_digits), 32'h2222);
    check("t5_held_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t5_drop", 32'(out_valid), 32'h0);

    // Reset mid-collect
    out_ready = 1'b0;
    for (int i = 0; i < ND; i++) show(i, PAT[1], 4);
    show(0, PAT[8], 4);
    show(1, PAT[8], 4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_digits", 32'(out_digits), 32'h0);
    check("t6_rst_err", 32'(out_err), 32'h0);
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    f0 = m_frames;
    @(negedge clk);
    show(2, PAT[5], 4);
    show(3, PAT[5], 4);
    show(0, PAT[4], 4);
    show(1, PAT[3], 4);
    show(2, PAT[2], 4);
    show(3, PAT[1], 4);
    blank(4);
    #1;
    check("t6_frame", 32'(last_frame), 32'h1234);
    check("t6_count", 32'(m_frames - f0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive side of the multiplexed active-low 7-segment display bus.
- Samples scanned segment/digit-enable lines and decodes each stable segment pattern back to a 4-bit digit.
- Assembles one full frame of NUM_DIGITS digits aligned to digit 0, then presents it on a valid/ready output.
- Used for loopback self-check of the display path and for reading digit entry from an external scanned display.

Parameters:
- NUM_DIGITS, 4: digits per frame; legal range 1..8.
- STABLE_CNT, 3: consecutive identical samples required before a digit is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- seg_in  input  7  segment lines, active-low, bit6=g .. bit0=a.
- dig_en_in  input  NUM_DIGITS  digit enables, active-low; exactly one low bit = valid scan slot.
- out_digits  output  4*NUM_DIGITS  decoded frame; digit k in bits [4k+3:4k].
- out_err  output  NUM_DIGITS  per-digit undecodable-pattern flag.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- overrun  output  1  one-cycle pulse: unaccepted frame replaced by a newer one.

Behaviour:
- Reset: out_digits=0, out_err=0, out_valid=0, overrun=0, FSM=SYNC, capture mask=0, stability counter=0, sample registers=all-ones (blank, no digit).
- Input stage: seg_in and dig_en_in are registered once. All logic below operates on the registered copies.
- Slot detect: exactly one dig_en bit low gives active index k. Zero or more than one low bit means no slot, and the counter clears to 0.
- Stability:
  - The (k, pattern) pair is compared with the previous cycle's pair.
  - Same pair: counter increments, saturating at STABLE_CNT.
  - Different pair: counter loads 1.
  - Capture of digit k happens only on the cycle the counter transitions to STABLE_CNT, so there is one capture per dwell.
- Decode (legal patterns only):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - Any other pattern, including blank 1111111, gives nibble 0 and err=1.
- FSM:
  - SYNC: captures are ignored except digit 0. A digit-0 capture stores it, sets mask=bit0, and moves to COLLECT.
  - COLLECT:
    - A capture of k stores the nibble/err in shadow slot k and sets mask bit k.
    - A digit-0 capture while mask is not full restarts the frame: mask=bit0, stays in COLLECT.
    - A repeat capture of an already-set k!=0 overwrites that slot.
    - Mask full gives frame complete: the shadow is transferred to the out_* registers on the next edge, out_valid=1, mask=0, FSM=SYNC.
  - NUM_DIGITS=1: every digit-0 capture completes a frame.
- Latency: final digit held stable on the inputs from cycle t gives out_valid high in cycle t+STABLE_CNT+2.
- Handshake:
  - out_digits/out_err are held constant while out_valid=1 and out_ready=0.
  - out_valid&&out_ready clears out_valid on the next edge.
  - Frame complete together with out_valid&&out_ready: the new frame loads and out_valid stays 1, with no overrun.
  - Frame complete while out_valid=1 and out_ready=0: the new frame replaces the old one, out_valid stays 1, and overrun pulses for 1 cycle.
- Reset mid-frame: all state clears immediately (asynchronous); a partial frame is discarded.

Optional Feature:
- SEG7_HEX_EN defined: additionally decodes 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F with err=0.
- Undefined: these six patterns decode as nibble 0, err=1.
- Blank is an error in both builds.

Test Plan:
- NUM_DIGITS=4, STABLE_CNT=3: scan digits 0..3 showing 1,2,3,4, each dwelling 5 cycles, out_ready=1 -> out_digits=16'h4321, out_err=0, out_valid pulses 1 cycle, timed as t+5 after digit-3 dwell start.
- Start scan at digit 2, then full pass 0..3 showing 9,8,7,6 -> digits 2 and 3 before the first digit 0 are ignored; single frame 16'h6789.
- Digit 1 shows 0001000, held 4 cycles -> out_err=4'b0010 and nibble 0 (macro off); nibble A and err=0 (SEG7_HEX_EN on).
- Glitch: digit 0 shows 5 for 2 cycles, then 6 for 3 cycles -> captures 6 only; two enables low for 10 cycles -> no capture.
- out_ready=0 across two complete frames 0x1111 then 0x2222 -> overrun pulses once, out_digits=0x2222, value held until out_ready=1, then out_valid drops next edge.
- Assert rst_n=0 mid-COLLECT after 2 digits, release, complete a frame -> only digits after reset appear; all outputs 0 during reset.
